// File: rtl/flight_rd_arbiter.sv
// flight_rd_arbiter: shares the single read port of the subframe (FLIGHT)
// buffer between the CC/sound packer (requester 0) and the LPC transmit
// path (requester 1). One read per clock, in-order data return through a
// tag pipeline matched to the buffer read latency, busy stall, and sticky
// per-requester wait timeouts.
module flight_rd_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 32,
    parameter int RAM_LAT    = 2,
    parameter int PRIO_FIXED = 0,
    parameter int TIMEOUT    = 1000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          busy,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          vld0,
    output logic          vld1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] rd_FLIGHT,
    input  logic [DW-1:0] FLIGHT_out,
    output logic [1:0]    err,
    output logic [15:0]   cnt0,
    output logic [15:0]   cnt1
);

    localparam int WW = $clog2(TIMEOUT + 1);

    logic               rr_ptr;
    logic               elig0;
    logic               elig1;
    logic               win0;
    logic               win1;
    logic [RAM_LAT-1:0] tag_vld_p;
    logic [RAM_LAT-1:0] tag_id_p;
    logic [WW-1:0]      wait0;
    logic [WW-1:0]      wait1;
    logic               pend0;
    logic               pend1;

    // Grant counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Wait counters stop at TIMEOUT so they never wrap back to zero.
    function automatic logic [WW-1:0] sat_wait(input logic [WW-1:0] v);
        return (v == WW'(TIMEOUT)) ? v : v + WW'(1);
    endfunction

    // gnt is registered, so req is still high in the grant cycle; masking
    // with gnt keeps a single held request from being granted twice.
    assign elig0 = req0 & ~gnt0 & ~busy;
    assign elig1 = req1 & ~gnt1 & ~busy;
    assign pend0 = req0 & ~gnt0;
    assign pend1 = req1 & ~gnt1;

    // Pick the winner: tie broken by fixed priority or the round-robin pointer.
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (elig0 && elig1) begin
            if ((PRIO_FIXED != 0) || !rr_ptr) win0 = 1'b1;
            else                              win1 = 1'b1;
        end else begin
            win0 = elig0;
            win1 = elig1;
        end
    end

    // Issue the grant: pulse gnt, drive the buffer address, count, rotate pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rd_FLIGHT <= '0;
            rr_ptr    <= 1'b0;
            cnt0      <= '0;
            cnt1      <= '0;
        end else begin
            gnt0 <= win0;
            gnt1 <= win1;
            if (win0) begin
                rd_FLIGHT <= addr0;
                cnt0      <= sat_inc16(cnt0);
                rr_ptr    <= 1'b1;
            end else if (win1) begin
                rd_FLIGHT <= addr1;
                cnt1      <= sat_inc16(cnt1);
                rr_ptr    <= 1'b0;
            end
        end
    end

    // Tag pipeline: {valid, id} per grant, delayed to line up with FLIGHT_out.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_vld_p <= '0;
            tag_id_p  <= '0;
        end else begin
            tag_vld_p[0] <= win0 | win1;
            tag_id_p[0]  <= win1;
            for (int i = 1; i < RAM_LAT; i++) begin
                tag_vld_p[i] <= tag_vld_p[i-1];
                tag_id_p[i]  <= tag_id_p[i-1];
            end
        end
    end

    // Data return: capture buffer output and steer the valid pulse by tag id.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld0  <= 1'b0;
            vld1  <= 1'b0;
            rdata <= '0;
        end else begin
            vld0 <= tag_vld_p[RAM_LAT-1] & ~tag_id_p[RAM_LAT-1];
            vld1 <= tag_vld_p[RAM_LAT-1] &  tag_id_p[RAM_LAT-1];
            if (tag_vld_p[RAM_LAT-1]) rdata <= FLIGHT_out;
        end
    end

    // Wait timers: count ungranted pending cycles, latch err on reaching TIMEOUT.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait0 <= '0;
            wait1 <= '0;
            err   <= 2'b00;
        end else begin
            wait0 <= pend0 ? sat_wait(wait0) : '0;
            wait1 <= pend1 ? sat_wait(wait1) : '0;
            if (pend0 && (sat_wait(wait0) == WW'(TIMEOUT))) err[0] <= 1'b1;
            if (pend1 && (sat_wait(wait1) == WW'(TIMEOUT))) err[1] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_flight_rd_arbiter.sv
// Directed bench for flight_rd_arbiter: a round-robin instance with a short
// timeout and a fixed-priority instance, each reading a shared buffer model
// with two clocks of read latency.
module tb_flight_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busy = 1'b0;

    logic        req0 = 1'b0, req1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic        gnt0, gnt1, vld0, vld1;
    logic [31:0] rdata, flight_out;
    logic [7:0]  rd_flight;
    logic [1:0]  err;
    logic [15:0] cnt0, cnt1;

    logic        p_req0 = 1'b0, p_req1 = 1'b0;
    logic [7:0]  p_addr0 = '0, p_addr1 = '0;
    logic        p_gnt0, p_gnt1, p_vld0, p_vld1;
    logic [31:0] p_rdata, p_flight_out;
    logic [7:0]  p_rd_flight;
    logic [1:0]  p_err;
    logic [15:0] p_cnt0, p_cnt1;

    logic [31:0] mem [0:255];
    logic [31:0] q_main, q_prio;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Buffer model: one register stage after rd_FLIGHT gives two clocks of latency.
    always_ff @(posedge clk) begin
        q_main <= mem[rd_flight];
        q_prio <= mem[p_rd_flight];
    end
    assign flight_out   = q_main;
    assign p_flight_out = q_prio;

    flight_rd_arbiter #(.AW(8), .DW(32), .RAM_LAT(2), .PRIO_FIXED(0), .TIMEOUT(16)) dut (
        .clock(clk), .reset(rst), .busy(busy),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1), .vld0(vld0), .vld1(vld1),
        .rdata(rdata), .rd_FLIGHT(rd_flight), .FLIGHT_out(flight_out),
        .err(err), .cnt0(cnt0), .cnt1(cnt1)
    );

    flight_rd_arbiter #(.AW(8), .DW(32), .RAM_LAT(2), .PRIO_FIXED(1), .TIMEOUT(1000)) dut_prio (
        .clock(clk), .reset(rst), .busy(busy),
        .req0(p_req0), .addr0(p_addr0), .req1(p_req1), .addr1(p_addr1),
        .gnt0(p_gnt0), .gnt1(p_gnt1), .vld0(p_vld0), .vld1(p_vld1),
        .rdata(p_rdata), .rd_FLIGHT(p_rd_flight), .FLIGHT_out(p_flight_out),
        .err(p_err), .cnt0(p_cnt0), .cnt1(p_cnt1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [5:0] pv [0:7];
        logic       ev0, ev1;

        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[5] = 32'hDEAD_BEEF;

        // Reset, then idle for 20 clocks.
        do_reset();
        chk("rst_cnt0", cnt0, 16'h0);
        chk("rst_cnt1", cnt1, 16'h0);
        chk("rst_err", err, 2'b00);
        for (int i = 0; i < 20; i++) begin
            chk("idle_ctl", {gnt0, gnt1, vld0, vld1, err}, 6'b0);
            chk("idle_rd", {rd_flight, rdata}, 40'h0);
            tick();
        end

        // Single read from requester 0.
        req0 = 1'b1; addr0 = 8'h05;
        tick();
        chk("single_gnt", {gnt0, gnt1}, 2'b10);
        chk("single_addr", rd_flight, 8'h05);
        chk("single_cnt0", cnt0, 16'd1);
        req0 = 1'b0;
        tick();
        chk("single_vld_early", {vld0, vld1}, 2'b00);
        tick();
        chk("single_vld", {vld0, vld1}, 2'b10);
        chk("single_rdata", rdata, 32'hDEAD_BEEF);
        tick();
        chk("single_vld_pulse", {vld0, vld1}, 2'b00);

        // Both requesting: alternating grants, in-order return.
        do_reset();
        req0 = 1'b1; addr0 = 8'h10;
        req1 = 1'b1; addr1 = 8'h20;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("rr_gnt", {gnt0, gnt1}, {(i < 10) && (i % 2 == 0), (i < 10) && (i % 2 == 1)});
            if (i < 10) chk("rr_addr", rd_flight, (i % 2 == 0) ? 8'h10 : 8'h20);
            ev0 = (i >= 2) && ((i - 2) % 2 == 0);
            ev1 = (i >= 2) && ((i - 2) % 2 == 1);
            chk("rr_vld", {vld0, vld1}, {ev0, ev1});
            if (ev0) chk("rr_rdata0", rdata, 32'hC0DE_0010);
            if (ev1) chk("rr_rdata1", rdata, 32'hC0DE_0020);
            if (i == 9) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        chk("rr_cnt0", cnt0, 16'd5);
        chk("rr_cnt1", cnt1, 16'd5);

        // Fixed priority instance: {req0, req1, busy, exp_gnt0, exp_gnt1, unused}.
        pv[0] = 6'b110_10_0;
        pv[1] = 6'b011_00_0;
        pv[2] = 6'b110_10_0;
        pv[3] = 6'b010_01_0;
        pv[4] = 6'b110_10_0;
        pv[5] = 6'b110_01_0;
        pv[6] = 6'b110_10_0;
        pv[7] = 6'b000_00_0;
        p_addr0 = 8'h30; p_addr1 = 8'h40;
        for (int k = 0; k < 8; k++) begin
            p_req0 = pv[k][5];
            p_req1 = pv[k][4];
            busy   = pv[k][3];
            tick();
            chk("prio_gnt", {p_gnt0, p_gnt1}, {pv[k][2], pv[k][1]});
        end
        busy = 1'b0;
        tick();
        tick();
        chk("prio_cnt0", p_cnt0, 16'd4);
        chk("prio_cnt1", p_cnt1, 16'd2);

        // Busy stall with a read already in flight for requester 1.
        do_reset();
        req1 = 1'b1; addr1 = 8'h20;
        tick();
        chk("busy_gnt1", {gnt0, gnt1}, 2'b01);
        req1 = 1'b0;
        busy = 1'b1;
        req0 = 1'b1; addr0 = 8'h05;
        for (int j = 1; j <= 30; j++) begin
            tick();
            chk("busy_no_gnt", {gnt0, gnt1}, 2'b00);
            if (j == 2) begin
                chk("busy_vld1", {vld0, vld1}, 2'b01);
                chk("busy_rdata", rdata, 32'hC0DE_0020);
            end
        end
        busy = 1'b0;
        tick();
        chk("busy_release_gnt", {gnt0, gnt1}, 2'b10);
        chk("busy_release_addr", rd_flight, 8'h05);
        chk("busy_err0", err, 2'b01);
        req0 = 1'b0;
        tick();
        tick();
        chk("busy_vld0", {vld0, vld1}, 2'b10);
        chk("busy_rdata0", rdata, 32'hDEAD_BEEF);

        // Timeout on requester 1 while busy holds it off.
        do_reset();
        busy = 1'b1;
        req1 = 1'b1; addr1 = 8'h20;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (t == 15) chk("to_err_before", err, 2'b00);
            if (t == 16) chk("to_err_set", err, 2'b10);
        end
        chk("to_err_hold", err, 2'b10);
        busy = 1'b0;
        tick();
        chk("to_gnt1", {gnt0, gnt1}, 2'b01);
        req1 = 1'b0;
        tick();
        tick();
        chk("to_vld1", {vld0, vld1}, 2'b01);
        chk("to_err_sticky", err, 2'b10);

        // Reset right after a grant drops the in-flight read.
        do_reset();
        req0 = 1'b1; addr0 = 8'h05;
        tick();
        chk("rmid_gnt0", {gnt0, gnt1}, 2'b10);
        req0 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rmid_no_vld", {vld0, vld1}, 2'b00);
            tick();
        end
        chk("rmid_cnt", {cnt0, cnt1}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
